// File: rtl/idex_exec_stage.sv
// idex_exec_stage: MIPS ID/EX register, forwarding, ALU and EX/MEM register (ALU_OVF_EN adds ovfM)
module idex_exec_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             regwriteD,
  input  logic             memtoregD,
  input  logic             memwriteD,
  input  logic             alusrcD,
  input  logic             regdstD,
  input  logic [2:0]       alucontrolD,
  input  logic [WIDTH-1:0] rd1D,
  input  logic [WIDTH-1:0] rd2D,
  input  logic [WIDTH-1:0] signimmD,
  input  logic [REGW-1:0]  rsD,
  input  logic [REGW-1:0]  rtD,
  input  logic [REGW-1:0]  rdD,
  input  logic [1:0]       forwardAE,
  input  logic [1:0]       forwardBE,
  input  logic [WIDTH-1:0] resultW,
  output logic [REGW-1:0]  rsE,
  output logic [REGW-1:0]  rtE,
  output logic [REGW-1:0]  writeregE,
  output logic             regwriteE,
  output logic             memtoregE,
  output logic             regwriteM,
  output logic             memtoregM,
  output logic             memwriteM,
  output logic [WIDTH-1:0] aluoutM,
  output logic [WIDTH-1:0] writedataM,
  output logic [REGW-1:0]  writeregM,
`ifdef ALU_OVF_EN
  output logic             ovfM,
`endif
  output logic             illegalM
);
  typedef struct packed {
    logic             regwrite, memtoreg, memwrite, alusrc, regdst;
    logic [2:0]       alucontrol;
    logic [WIDTH-1:0] rd1, rd2, signimm;
    logic [REGW-1:0]  rs, rt, rd;
  } idex_t;
  typedef struct packed {
    logic             regwrite, memtoreg, memwrite, illegal;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif
    logic [WIDTH-1:0] aluout, writedata;
    logic [REGW-1:0]  writereg;
  } exmem_t;
  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  logic [WIDTH-1:0] src_a, fwd_b, src_b, sum, diff, res;
  logic sub_ovf, illegal, ovf;
  assign idex_d = flushE ? '0 : stallE ? idex_q :
    {regwriteD, memtoregD, memwriteD, alusrcD, regdstD, alucontrolD, rd1D, rd2D, signimmD, rsD, rtD, rdD};
  assign src_a = (forwardAE == 2'b01) ? resultW : (forwardAE == 2'b10) ? aluoutM : idex_q.rd1;
  assign fwd_b = (forwardBE == 2'b01) ? resultW : (forwardBE == 2'b10) ? aluoutM : idex_q.rd2;
  assign src_b = idex_q.alusrc ? idex_q.signimm : fwd_b;
  assign sum = src_a + src_b;
  assign diff = src_a - src_b;
  // slt takes the sign of A-B, flipped when the subtraction overflowed
  assign sub_ovf = (src_a[WIDTH-1] ^ src_b[WIDTH-1]) & (diff[WIDTH-1] ^ src_a[WIDTH-1]);
  always_comb begin
    res = '0;
    illegal = 1'b0;
    case (idex_q.alucontrol)
      3'b010:  res = sum;
      3'b110:  res = diff;
      3'b000:  res = src_a & src_b;
      3'b001:  res = src_a | src_b;
      3'b111:  res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      3'b100:  res = src_a & ~src_b;
      3'b101:  res = src_a | ~src_b;
      default: illegal = 1'b1;
    endcase
  end
`ifdef ALU_OVF_EN
  assign ovf = (idex_q.alucontrol == 3'b110) ? sub_ovf :
    (idex_q.alucontrol == 3'b010) & ~(src_a[WIDTH-1] ^ src_b[WIDTH-1]) & (sum[WIDTH-1] ^ src_a[WIDTH-1]);
`else
  assign ovf = 1'b0;
`endif
  // a stalled instruction stays in E, so M gets a bubble instead of a duplicate
  always_comb begin
    exmem_d = '0;
    if (!(stallE && !flushE)) begin
      exmem_d.regwrite  = idex_q.regwrite & ~illegal & ~ovf;
      exmem_d.memtoreg  = idex_q.memtoreg;
      exmem_d.memwrite  = idex_q.memwrite & ~illegal & ~ovf;
      exmem_d.illegal   = illegal;
`ifdef ALU_OVF_EN
      exmem_d.ovf       = ovf;
`endif
      exmem_d.aluout    = res;
      exmem_d.writedata = fwd_b;
      exmem_d.writereg  = writeregE;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  assign rsE        = idex_q.rs;
  assign rtE        = idex_q.rt;
  assign writeregE  = idex_q.regdst ? idex_q.rd : idex_q.rt;
  assign regwriteE  = idex_q.regwrite;
  assign memtoregE  = idex_q.memtoreg;
  assign regwriteM  = exmem_q.regwrite;
  assign memtoregM  = exmem_q.memtoreg;
  assign memwriteM  = exmem_q.memwrite;
  assign aluoutM    = exmem_q.aluout;
  assign writedataM = exmem_q.writedata;
  assign writeregM  = exmem_q.writereg;
  assign illegalM   = exmem_q.illegal;
`ifdef ALU_OVF_EN
  assign ovfM       = exmem_q.ovf;
`endif
endmodule

// File: tb/tb_idex_exec_stage.sv
// tb_idex_exec_stage: directed checks of the execute stage (set ALU_OVF_EN to test ovfM)
module tb_idex_exec_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0, stallE = 1'b0, flushE = 1'b0;
  logic regwriteD = 1'b0, memtoregD = 1'b0, memwriteD = 1'b0, alusrcD = 1'b0, regdstD = 1'b0;
  logic [2:0] alucontrolD = '0;
  logic [31:0] rd1D = '0, rd2D = '0, signimmD = '0, resultW = '0;
  logic [4:0] rsD = '0, rtD = '0, rdD = '0;
  logic [1:0] forwardAE = '0, forwardBE = '0;
  logic [4:0] rsE, rtE, writeregE, writeregM;
  logic regwriteE, memtoregE, regwriteM, memtoregM, memwriteM, illegalM;
  logic [31:0] aluoutM, writedataM;
`ifdef ALU_OVF_EN
  logic ovfM;
`endif
  int checks = 0, failures = 0;

  idex_exec_stage dut (
    .clk(clk), .reset_n(reset_n), .stallE(stallE), .flushE(flushE),
    .regwriteD(regwriteD), .memtoregD(memtoregD), .memwriteD(memwriteD),
    .alusrcD(alusrcD), .regdstD(regdstD), .alucontrolD(alucontrolD),
    .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD),
    .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM),
`ifdef ALU_OVF_EN
    .ovfM(ovfM),
`endif
    .illegalM(illegalM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // forwarding selects apply while the instruction sits in E (after the first edge)
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] fa, input logic [1:0] fb);
    alucontrolD = op; rd1D = a; rd2D = b; forwardAE = 2'b00; forwardBE = 2'b00;
    tick();
    forwardAE = fa; forwardBE = fb;
    tick();
  endtask

  initial begin
    rd1D = 5; rd2D = 3; alucontrolD = 3'b010; regwriteD = 1; regdstD = 1; rdD = 7; rsD = 2; rtD = 4;
    tick(); tick();
    chk("rst_aluoutM", aluoutM, 0);
    chk("rst_regwriteM", regwriteM, 0);
    chk("rst_writeregM", writeregM, 0);
    chk("rst_rsE", rsE, 0);
    chk("rst_regwriteE", regwriteE, 0);
    chk("rst_illegalM", illegalM, 0);
    reset_n = 1;
    tick();
    chk("lat_regwriteE", regwriteE, 1);
    chk("lat_writeregE", writeregE, 7);
    chk("lat_rtE", rtE, 4);
    chk("lat_aluoutM_early", aluoutM, 0);
    tick();
    chk("lat_aluoutM", aluoutM, 8);
    chk("lat_regwriteM", regwriteM, 1);
    chk("lat_writeregM", writeregM, 7);

    run(3'b000, 32'hF0, 32'h3C, 0, 0); chk("and", aluoutM, 32'h30);
    run(3'b001, 32'hF0, 32'h3C, 0, 0); chk("or", aluoutM, 32'hFC);
    run(3'b100, 32'hF0, 32'h3C, 0, 0); chk("andn", aluoutM, 32'hC0);
    run(3'b101, 32'hF0, 32'h3C, 0, 0); chk("orn", aluoutM, 32'hFFFF_FFF3);
    run(3'b110, 32'hF0, 32'h3C, 0, 0); chk("sub", aluoutM, 32'hB4);
    chk("sub_illegalM", illegalM, 0);
    run(3'b111, 32'hFFFF_FFFF, 32'h1, 0, 0); chk("slt_neg", aluoutM, 1);
    run(3'b111, 32'h1, 32'hFFFF_FFFF, 0, 0); chk("slt_pos", aluoutM, 0);
    run(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0); chk("slt_extreme", aluoutM, 1);

    alusrcD = 1; signimmD = 32'hFFFF_FFFC;
    run(3'b010, 10, 32'h99, 0, 0);
    chk("imm_aluoutM", aluoutM, 6);
    chk("imm_writedataM", writedataM, 32'h99);
    signimmD = 1;
    run(3'b010, 10, 32'h99, 2'b10, 2'b00); chk("fwdA_mem", aluoutM, 7);
    resultW = 32'h55;
    run(3'b010, 10, 32'h99, 2'b00, 2'b01);
    chk("fwdB_wb", writedataM, 32'h55);
    chk("fwdB_imm_alu", aluoutM, 11);
    run(3'b010, 10, 32'h99, 2'b11, 2'b11);
    chk("fwd11_alu", aluoutM, 11);
    chk("fwd11_wd", writedataM, 32'h99);
    alusrcD = 0; forwardAE = 0; forwardBE = 0;

    run(3'b010, 5, 3, 0, 0); chk("pre_stall", aluoutM, 8);
    rsD = 9; rtD = 10; rd1D = 20; stallE = 1;
    tick();
    chk("stall1_rsE", rsE, 2);
    chk("stall1_aluoutM", aluoutM, 0);
    chk("stall1_regwriteM", regwriteM, 0);
    tick();
    chk("stall2_rsE", rsE, 2);
    chk("stall2_aluoutM", aluoutM, 0);
    chk("stall2_regwriteM", regwriteM, 0);
    stallE = 0;
    tick();
    chk("unstall_rsE", rsE, 9);
    chk("unstall_aluoutM", aluoutM, 8);
    chk("unstall_regwriteM", regwriteM, 1);
    flushE = 1; stallE = 1;
    tick();
    chk("flush_rsE", rsE, 0);
    chk("flush_rtE", rtE, 0);
    chk("flush_regwriteE", regwriteE, 0);
    chk("flush_aluoutM", aluoutM, 23);
    flushE = 0; stallE = 0;
    tick();
    chk("bubble_aluoutM", aluoutM, 0);
    chk("bubble_regwriteM", regwriteM, 0);
    chk("bubble_illegalM", illegalM, 0);

    rd1D = 5; rd2D = 3; memwriteD = 1; alucontrolD = 3'b011;
    tick();
    alucontrolD = 3'b010;
    tick();
    chk("ill_illegalM", illegalM, 1);
    chk("ill_regwriteM", regwriteM, 0);
    chk("ill_memwriteM", memwriteM, 0);
    chk("ill_aluoutM", aluoutM, 0);
    tick();
    chk("post_ill_illegalM", illegalM, 0);
    chk("post_ill_memwriteM", memwriteM, 1);
    chk("post_ill_aluoutM", aluoutM, 8);
    memwriteD = 0;

    run(3'b010, 32'h7FFF_FFFF, 32'h1, 0, 0);
    chk("ovf_add_aluoutM", aluoutM, 32'h8000_0000);
`ifdef ALU_OVF_EN
    chk("ovf_add_ovfM", ovfM, 1);
    chk("ovf_add_regwriteM", regwriteM, 0);
`else
    chk("ovf_add_regwriteM", regwriteM, 1);
`endif
    run(3'b110, 32'h8000_0000, 32'h1, 0, 0);
    chk("ovf_sub_aluoutM", aluoutM, 32'h7FFF_FFFF);
`ifdef ALU_OVF_EN
    chk("ovf_sub_ovfM", ovfM, 1);
    run(3'b010, 5, 3, 0, 0);
    chk("no_ovf_ovfM", ovfM, 0);
`else
    chk("ovf_sub_regwriteM", regwriteM, 1);
`endif

    rd1D = 5; rd2D = 3; alucontrolD = 3'b010;
    reset_n = 0;
    #1;
    chk("midrst_aluoutM", aluoutM, 0);
    chk("midrst_regwriteE", regwriteE, 0);
    #2 reset_n = 1;
    tick();
    chk("restart_aluoutM", aluoutM, 0);
    chk("restart_regwriteM", regwriteM, 0);
    chk("restart_regwriteE", regwriteE, 1);
    tick();
    chk("restart2_aluoutM", aluoutM, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/idex_exec_stage.md
Name: idex_exec_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the ALU control decoder.
- Contains the ID/EX pipeline register, the E-stage forwarding muxes and ALU, and the EX/MEM pipeline register.
- Consumes the decode-stage controls and operands, including the 3-bit ALU control code.
- Produces registered M-stage results, plus the E-stage register fields the hazard unit needs.

Parameters:
- WIDTH, 32, datapath width in bits.
- REGW, 5, register-specifier width.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
stallE  in  1  hold the ID/EX register
flushE  in  1  load a bubble into the ID/EX register
regwriteD  in  1  decode control
memtoregD  in  1  decode control
memwriteD  in  1  decode control
alusrcD  in  1  decode control
regdstD  in  1  decode control
alucontrolD  in  3  ALU operation code from the decoder
rd1D  in  WIDTH  register-file read data A
rd2D  in  WIDTH  register-file read data B
signimmD  in  WIDTH  sign-extended immediate
rsD  in  REGW  register specifier
rtD  in  REGW  register specifier
rdD  in  REGW  register specifier
forwardAE  in  2  forwarding select, operand A
forwardBE  in  2  forwarding select, operand B
resultW  in  WIDTH  writeback result, used for forwarding
rsE  out  REGW  to hazard unit
rtE  out  REGW  to hazard unit
writeregE  out  REGW  to hazard unit
regwriteE  out  1  to hazard unit
memtoregE  out  1  to hazard unit
regwriteM  out  1  M-stage control
memtoregM  out  1  M-stage control
memwriteM  out  1  M-stage control
aluoutM  out  WIDTH  registered ALU result
writedataM  out  WIDTH  forwarded operand B
writeregM  out  REGW  destination register
illegalM  out  1  unsupported ALU code was executed

Behaviour:
- Reset: one clock, reset_n asynchronous active-low. While reset_n=0, every ID/EX and EX/MEM register, and therefore every output, is 0.
- Latency: D inputs are captured at edge N, and their ALU result appears on the M outputs after edge N+1. Two registers, no combinational path from D inputs to any output.
- ID/EX update priority on each edge:
  - flushE=1: bubble. All controls, alucontrolE, data and specifiers load 0.
  - else stallE=1: hold.
  - else: load the D inputs.
  - flushE overrides stallE when both are asserted.
- EX/MEM update:
  - Loads the E-stage results every edge, with no stall.
  - If stallE=1 and flushE=0, loads a bubble: all controls 0, illegalM 0, data 0. This keeps a held instruction from executing twice.
- Forwarding (separately for A and B):
  - 00 → rd1E / rd2E.
  - 01 → resultW.
  - 10 → aluoutM.
  - 11 is reserved and behaves as 00.
- Operand selection: srcB = alusrcE ? signimmE : forwarded B. writedataM receives forwarded B, never the immediate.
- Destination: writeregE = regdstE ? rdE : rtE.
- ALU codes:
  - 010: add.
  - 110: subtract.
  - 000: AND.
  - 001: OR.
  - 111: signed set-less-than; result is 1 or 0, zero-extended to WIDTH.
  - 100: A AND NOT B.
  - 101: A OR NOT B.
  - 011, or any X/Z code: result 0 and illegal=1.
- Arithmetic: two's complement, modulo 2^WIDTH, carry-out discarded. slt uses the sign of (A−B) corrected by signed overflow, so it is correct at the extremes.
- Illegal code: illegalM=1 for exactly the one M cycle of that instruction. Its regwriteM and memwriteM are forced to 0.
- A bubble never asserts illegalM, because alucontrol=000 is legal.
- Reset deasserted mid-stream: the pipeline restarts empty. Bubbles leave both registers on the first edge after release.

Optional Feature:
- Macro: ALU_OVF_EN.
- When defined:
  - Adds output port ovfM (1 bit, reset 0).
  - For add (010) or subtract (110) with signed overflow, ovfM=1 for that instruction's M cycle.
  - regwriteM and memwriteM are forced to 0 for that instruction; aluoutM still carries the wrapped result.
- When undefined:
  - Port ovfM is absent.
  - Overflow wraps silently and controls are never suppressed.

Test Plan:
- Reset/latency: hold reset_n=0, then release. Drive rd1D=5, rd2D=3, alucontrolD=010, regwriteD=1, regdstD=1, rdD=7, forwards 00. Required: aluoutM=8, regwriteM=1 and writeregM=7 two edges later; all outputs 0 during reset.
- ALU op coverage, alusrcD=0:
  - rd1D=0x0000_00F0, rd2D=0x0000_003C: 000→0x30, 001→0xFC, 100→0xC0, 110→0xB4.
  - rd1D=0xFFFF_FFFF, rd2D=1: 111→1. rd1D=1, rd2D=0xFFFF_FFFF: 111→0.
- Immediate and forwarding:
  - alusrcD=1, signimmD=0xFFFF_FFFC, rd1D=10, 010 → aluoutM=6.
  - Then forwardAE=10 with an add of 1 → 7.
  - forwardBE=01 with resultW=0x55 → writedataM=0x55.
- Stall/flush:
  - stallE=1 for 2 cycles → E outputs unchanged; aluoutM=0 and regwriteM=0 for those 2 M cycles.
  - flushE=1 together with stallE=1 → rsE, rtE, regwriteE all 0 next cycle.
- Illegal code: alucontrolD=011 with regwriteD=1, memwriteD=1 → illegalM=1, regwriteM=0, memwriteM=0, aluoutM=0 for one cycle.
- Overflow (ALU_OVF_EN defined): 0x7FFF_FFFF + 1 → ovfM=1, regwriteM=0, aluoutM=0x8000_0000. Undefined → regwriteM=1, same aluoutM.
